// File: rtl/stopwatch_lap_ctrl_if.sv
// Button/tick inputs and display outputs of the stopwatch lap controller.
// The master side drives the button pulses and the tick and reads the display.
// The slave side is the controller itself.
interface stopwatch_lap_ctrl_if;
  logic       tick;
  logic       start_stop;
  logic       lap_reset;
  logic [3:0] digit0;
  logic [5:0] digit12;
  logic [3:0] digit3;
  logic       running;
  logic       lap_active;

  modport master (
    output tick, start_stop, lap_reset,
    input  digit0, digit12, digit3, running, lap_active
  );

  modport slave (
    input  tick, start_stop, lap_reset,
    output digit0, digit12, digit3, running, lap_active
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch run/pause/lap/clear controller with a min:sec.tenths live counter.
// A lap register can freeze the display while the live counter keeps going.
// Display outputs are decoded from registers only.
module stopwatch_lap_ctrl (
  input  logic                clk,
  input  logic                reset,
  stopwatch_lap_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [3:0] ten_q, ten_d;
  logic [3:0] lap_min_q, lap_min_d;
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [3:0] lap_ten_q, lap_ten_d;

  logic       count_en;
  logic       ten_wrap, sec_wrap, min_wrap;
  logic [3:0] ten_inc, min_inc;
  logic [5:0] sec_inc;

  // Incremented live value; a field at or beyond its maximum wraps to 0 and carries.
  always_comb begin
    ten_wrap = (ten_q >= 4'd9);
    ten_inc  = ten_wrap ? 4'd0 : ten_q + 4'd1;
    sec_wrap = ten_wrap && (sec_q >= 6'd59);
    sec_inc  = sec_q;
    if (ten_wrap) begin
      sec_inc = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
    end
    min_wrap = sec_wrap && (min_q >= 4'd9);
    min_inc  = min_q;
    if (sec_wrap) begin
      min_inc = (min_q >= 4'd9) ? 4'd0 : min_q + 4'd1;
    end
  end

  // Next state, counting and lap capture; a full-range wrap overrides any button.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    ten_d     = ten_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    lap_ten_d = lap_ten_q;
    count_en  = sw.tick && ((state_q == RUN) || (state_q == LAP));

    if (count_en) begin
      min_d = min_inc;
      sec_d = sec_inc;
      ten_d = ten_inc;
    end

    case (state_q)
      IDLE: begin
        if (sw.start_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sw.start_stop) begin
          state_d = PAUSE;
        end else if (sw.lap_reset) begin
          state_d   = LAP;
          lap_min_d = min_q;
          lap_sec_d = sec_q;
          lap_ten_d = ten_q;
        end
      end
      LAP: begin
        if (sw.start_stop) begin
          state_d = PAUSE;
        end else if (sw.lap_reset) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (sw.start_stop) begin
          state_d = RUN;
        end else if (sw.lap_reset) begin
          state_d   = IDLE;
          min_d     = 4'd0;
          sec_d     = 6'd0;
          ten_d     = 4'd0;
          lap_min_d = 4'd0;
          lap_sec_d = 6'd0;
          lap_ten_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (count_en && min_wrap) begin
      state_d   = IDLE;
      lap_min_d = lap_min_q;
      lap_sec_d = lap_sec_q;
      lap_ten_d = lap_ten_q;
    end
  end

  // State, live counter and lap register, all cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      min_q     <= 4'd0;
      sec_q     <= 6'd0;
      ten_q     <= 4'd0;
      lap_min_q <= 4'd0;
      lap_sec_q <= 6'd0;
      lap_ten_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      ten_q     <= ten_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      lap_ten_q <= lap_ten_d;
    end
  end

  // Display decode: the lap register while frozen, otherwise the live counter.
  always_comb begin
    sw.running    = (state_q == RUN) || (state_q == LAP);
    sw.lap_active = (state_q == LAP);
    sw.digit3     = min_q;
    sw.digit12    = sec_q;
    sw.digit0     = ten_q;
    if (state_q == LAP) begin
      sw.digit3  = lap_min_q;
      sw.digit12 = lap_sec_q;
      sw.digit0  = lap_ten_q;
    end
  end

endmodule
